// File: rtl/lvds_out_serializer.sv
// rtl/lvds_out_serializer.sv - start-bit framed MSB-first LVDS transmit serializer with pad OEN sequencing
//
// Purpose: accepts parallel words on a valid/ready handshake, frames each with a
// start bit (0) and shifts it MSB-first onto a complementary pad pair. The pair
// idles at mark (1/0) and is wrapped in guard intervals around output enable and
// disable so the far-end receiver never sees a floating or glitching pair.
//
// Optional feature macro: LVDS_TX_PARITY_EN appends an even-parity bit after the LSB.
//
// Ports:
//   clk       in   transmit bit clock, one serial bit per cycle
//   rst       in   asynchronous active-high reset
//   lvdsen    in   transmitter enable (level)
//   tx_data   in   word to send, sampled on accept
//   tx_valid  in   word available
//   tx_ready  out  block can take a word this cycle (combinational)
//   out_padp  out  true leg of the serial pair
//   out_padn  out  complement leg
//   oen       out  pad output enable, active-low (1 tristates the pads)
//   busy      out  high whenever the block is not OFF

module lvds_out_serializer #(
  parameter int WIDTH        = 8,
  parameter int GUARD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lvdsen,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             out_padp,
  output logic             out_padn,
  output logic             oen,
  output logic             busy
);

`ifdef LVDS_TX_PARITY_EN
  localparam int LAST_BIT = WIDTH + 1;
`else
  localparam int LAST_BIT = WIDTH;
`endif
  // Counter value while the final bit of the frame is on the pads; 0 is the start bit.
  localparam int             CW         = $clog2(LAST_BIT + 2);
  localparam logic [CW-1:0]  LAST_CNT   = CW'(LAST_BIT);
  localparam logic [3:0]     GUARD_LAST = 4'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_WAKE,
    S_IDLE,
    S_SHIFT,
    S_DRAIN
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [3:0]       guard_cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic             padp_q;
  logic             padn_q;
  logic             oen_q;
  logic             busy_q;
`ifdef LVDS_TX_PARITY_EN
  logic             parity_q;
`endif

  logic last_bit;
  logic accept;

  assign last_bit = (state_q == S_SHIFT) && (bit_cnt_q == LAST_CNT);
  // Readiness on the last bit lets a new start bit follow with no mark gap.
  assign tx_ready = lvdsen && ((state_q == S_IDLE) || last_bit);
  assign accept   = tx_valid && tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_OFF;
      bit_cnt_q   <= '0;
      guard_cnt_q <= '0;
      shift_q     <= '0;
      padp_q      <= 1'b0;
      padn_q      <= 1'b0;
      oen_q       <= 1'b1;
      busy_q      <= 1'b0;
`ifdef LVDS_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else if (accept) begin
      // Only reachable from IDLE or the last SHIFT bit: load and drive the start bit.
      state_q   <= S_SHIFT;
      bit_cnt_q <= '0;
      shift_q   <= tx_data;
`ifdef LVDS_TX_PARITY_EN
      parity_q  <= ^tx_data;
`endif
      padp_q    <= 1'b0;
      padn_q    <= 1'b1;
    end else begin
      case (state_q)
        S_OFF: begin
          if (lvdsen) begin
            state_q     <= S_WAKE;
            guard_cnt_q <= '0;
            oen_q       <= 1'b0;
            busy_q      <= 1'b1;
            padp_q      <= 1'b1;
            padn_q      <= 1'b0;
          end
        end
        S_WAKE: begin
          if (!lvdsen) begin
            state_q     <= S_DRAIN;
            guard_cnt_q <= '0;
          end else if (guard_cnt_q == GUARD_LAST) begin
            state_q <= S_IDLE;
          end else begin
            guard_cnt_q <= guard_cnt_q + 4'd1;
          end
        end
        S_IDLE: begin
          if (!lvdsen) begin
            state_q     <= S_DRAIN;
            guard_cnt_q <= '0;
          end
        end
        S_SHIFT: begin
          if (last_bit) begin
            // Frame complete without a follow-on word: return to mark.
            bit_cnt_q   <= '0;
            padp_q      <= 1'b1;
            padn_q      <= 1'b0;
            guard_cnt_q <= '0;
            state_q     <= lvdsen ? S_IDLE : S_DRAIN;
          end else begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
`ifdef LVDS_TX_PARITY_EN
            if (bit_cnt_q == CW'(WIDTH)) begin
              padp_q <= parity_q;
              padn_q <= ~parity_q;
            end else
`endif
            begin
              padp_q  <= shift_q[WIDTH-1];
              padn_q  <= ~shift_q[WIDTH-1];
              shift_q <= {shift_q[WIDTH-2:0], 1'b0};
            end
          end
        end
        S_DRAIN: begin
          if (lvdsen) begin
            state_q <= S_IDLE;
          end else if (guard_cnt_q == GUARD_LAST) begin
            state_q     <= S_OFF;
            guard_cnt_q <= '0;
            oen_q       <= 1'b1;
            busy_q      <= 1'b0;
            padp_q      <= 1'b0;
            padn_q      <= 1'b0;
          end else begin
            guard_cnt_q <= guard_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= S_OFF;
          oen_q   <= 1'b1;
          busy_q  <= 1'b0;
          padp_q  <= 1'b0;
          padn_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_padp = padp_q;
  assign out_padn = padn_q;
  assign oen      = oen_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_lvds_out_serializer.sv
// tb/tb_lvds_out_serializer.sv - scoreboard bench for lvds_out_serializer

module tb_lvds_out_serializer;

  localparam int W = 8;
  localparam int G = 2;
`ifdef LVDS_TX_PARITY_EN
  localparam int FL = W + 2;
`else
  localparam int FL = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         lvdsen = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic         out_padp;
  logic         out_padn;
  logic         oen;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]  sb_q[$];
  int            mon_cnt = 0;
  logic [FL-2:0] mon_word;

  lvds_out_serializer #(.WIDTH(W), .GUARD_CYCLES(G)) dut (
    .clk      (clk),
    .rst      (rst),
    .lvdsen   (lvdsen),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .out_padp (out_padp),
    .out_padn (out_padn),
    .oen      (oen),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Start bit, data MSB-first, optional even parity; right-aligned.
  function automatic logic [63:0] frame_bits(input logic [W-1:0] w);
`ifdef LVDS_TX_PARITY_EN
    return {54'b0, 1'b0, w, ^w};
`else
    return {55'b0, 1'b0, w};
`endif
  endfunction

  // Frame monitor: pad legality every cycle, words reassembled and scored.
  always @(negedge clk) begin
    logic [63:0] fb;
    logic [W-1:0] ew;
    if (rst) begin
      mon_cnt = 0;
    end else begin
      if (oen) check("off_pads", {out_padp, out_padn}, 2'b00);
      else     check("diff_pair", out_padp ^ out_padn, 1);
      if (mon_cnt == 0) begin
        if (!oen && !out_padp) begin
          mon_cnt  = 1;
          mon_word = '0;
        end
      end else begin
        mon_word = {mon_word[FL-3:0], out_padp};
        mon_cnt++;
        if (mon_cnt == FL) begin
          check("sb_nonempty", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            ew = sb_q.pop_front();
            fb = frame_bits(ew);
            check("sb_word", mon_word, fb[FL-2:0]);
          end
          mon_cnt = 0;
        end
      end
    end
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, tx_ready, 1);
  endtask

  task automatic enable_and_check_wake();
    lvdsen = 1'b1;
    @(negedge clk);
    for (int i = 0; i < G; i++) begin
      check("wake_oen", oen, 0);
      check("wake_mark", {out_padp, out_padn}, 2'b10);
      check("wake_rdy", tx_ready, 0);
      check("wake_busy", busy, 1);
      @(negedge clk);
    end
    check("wake_ready", tx_ready, 1);
  endtask

  task automatic send_capture(input logic [W-1:0] w, input int ncyc, output logic [63:0] seq);
    wait_ready("send_ready");
    tx_data  = w;
    tx_valid = 1'b1;
    sb_q.push_back(w);
    seq = '0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (i == 0) tx_valid = 1'b0;
      seq = {seq[62:0], out_padp};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] seq;
    logic [63:0] oseq;
    logic [63:0] exp;
    int rcnt;

    @(negedge clk);
    check("rst_oen", oen, 1);
    check("rst_pads", {out_padp, out_padn}, 2'b00);
    check("rst_rdy", tx_ready, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("off_hold", oen, 1);

    enable_and_check_wake();

    // Single word 0xA5
    send_capture(8'hA5, FL + 1, seq);
`ifdef LVDS_TX_PARITY_EN
    check("a5_seq", seq, 64'b01010010101);
`else
    check("a5_seq", seq, 64'b0101001011);
`endif

    // Parity-sensitive words
    send_capture(8'h07, FL + 1, seq);
    check("w07_seq", seq, (frame_bits(8'h07) << 1) | 64'd1);
`ifdef LVDS_TX_PARITY_EN
    check("par07", seq[1], 1);
`endif
    send_capture(8'h03, FL + 1, seq);
    check("w03_seq", seq, (frame_bits(8'h03) << 1) | 64'd1);
`ifdef LVDS_TX_PARITY_EN
    check("par03", seq[1], 0);
`endif

    // Back-to-back 0x00 then 0xFF
    wait_ready("b2b_ready");
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    sb_q.push_back(8'h00);
    seq  = '0;
    rcnt = 0;
    for (int i = 0; i <= 2 * FL; i++) begin
      @(negedge clk);
      seq = {seq[62:0], out_padp};
      if (tx_ready && i < 2 * FL) rcnt++;
      if (i == FL - 1) begin
        check("b2b_last_rdy", tx_ready, 1);
        tx_data = 8'hFF;
        sb_q.push_back(8'hFF);
      end
      if (i == FL) tx_valid = 1'b0;
    end
    exp = (((frame_bits(8'h00) << FL) | frame_bits(8'hFF)) << 1) | 64'd1;
    check("b2b_seq", seq, exp);
    check("b2b_rdy_pulses", rcnt, 2);

    // Disable on data bit 3 of 0x3C while another word is offered
    wait_ready("dis_ready");
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    sb_q.push_back(8'h3C);
    seq  = '0;
    oseq = '0;
    rcnt = 0;
    for (int i = 0; i < FL + G + 2; i++) begin
      @(negedge clk);
      if (i == 0) tx_data = 8'h99;
      if (i == 4) lvdsen = 1'b0;
      seq  = {seq[62:0], out_padp};
      oseq = {oseq[62:0], oen};
      if (tx_ready) rcnt++;
    end
    tx_valid = 1'b0;
    check("dis_seq", seq, (frame_bits(8'h3C) << (G + 2)) | 64'b1100);
    check("dis_oen", oseq, 64'b11);
    check("dis_no_rdy", rcnt, 0);
    check("dis_busy", busy, 0);

    // Re-enable on first drain cycle
    enable_and_check_wake();
    wait_ready("re_ready");
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    sb_q.push_back(8'h5A);
    for (int i = 0; i <= FL; i++) begin
      @(negedge clk);
      if (i == 0) tx_valid = 1'b0;
      if (i == FL - 1) lvdsen = 1'b0;
      if (i == FL) begin
        check("drain_oen", oen, 0);
        check("drain_mark", out_padp, 1);
        check("drain_rdy", tx_ready, 0);
        lvdsen = 1'b1;
      end
    end
    @(negedge clk);
    check("re_idle_oen", oen, 0);
    check("re_idle_rdy", tx_ready, 1);
    check("re_idle_busy", busy, 1);
    send_capture(8'h81, FL + 1, seq);
    check("re_seq", seq, (frame_bits(8'h81) << 1) | 64'd1);

    // Reset mid-frame, release, then enable again
    wait_ready("mr_ready");
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    tx_valid = 1'b0;
    rst      = 1'b1;
    lvdsen   = 1'b0;
    #1;
    check("mr_oen", oen, 1);
    check("mr_pads", {out_padp, out_padn}, 2'b00);
    check("mr_rdy", tx_ready, 0);
    check("mr_busy", busy, 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mr_off", oen, 1);
    enable_and_check_wake();
    send_capture(8'h96, FL + 1, seq);
    check("mr_seq", seq, (frame_bits(8'h96) << 1) | 64'd1);

    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
